// File: rtl/mmu_sequencer_if.sv
// AXI-Stream result port of the matrix-multiply sequencer: one beat per result diagonal.
interface mmu_sequencer_if;
  logic tvalid;
  logic tlast;
  logic tready;

  modport master (output tvalid, output tlast, input tready);
  modport slave  (input tvalid, input tlast, output tready);
endinterface

// File: rtl/mmu_sequencer.sv
// Control FSM for a SIZE x SIZE systolic matrix multiply: clear, feed N operand vectors,
// flush the skew with zeros, then stream N result diagonals over AXI-Stream.
module mmu_sequencer #(
  parameter int SIZE      = 4,
  parameter int CFG_BITS  = 3,
  parameter int ADDR_BITS = $clog2(SIZE)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [CFG_BITS-1:0]  rf_matrix_size,
  output logic                 o_array_reset,
  output logic                 o_array_valid,
  output logic [ADDR_BITS-1:0] o_feed_addr,
  output logic                 o_feed_zero,
  output logic                 o_diag_shift,
  mmu_sequencer_if.master      m00_axis,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err
);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, STREAM} state_t;

  state_t               state;
  logic [ADDR_BITS-1:0] n_m1;     // latched N-1 for the current run
  logic [ADDR_BITS:0]   cnt;      // FLUSH needs up to 2N-2 counts
  logic [ADDR_BITS-1:0] cnt_lo;

  logic                 array_reset_q;
  logic                 array_valid_q;
  logic [ADDR_BITS-1:0] feed_addr_q;
  logic                 feed_zero_q;
  logic                 tvalid_q;
  logic                 tlast_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;

  // N = 2^(size+1) fits the array exactly when size+1 <= log2(SIZE).
  logic                 size_ok;
  logic [ADDR_BITS:0]   n_req;
  logic [ADDR_BITS-1:0] n_req_m1;
  logic [ADDR_BITS:0]   flush_last;
  logic                 abort_ok;

  assign size_ok    = (32'(rf_matrix_size) < ADDR_BITS);
  assign n_req      = (ADDR_BITS+1)'(1) << (rf_matrix_size + CFG_BITS'(1));
  assign n_req_m1   = ADDR_BITS'(n_req - (ADDR_BITS+1)'(1));
  assign flush_last = {n_m1, 1'b0} - (ADDR_BITS+1)'(1);
  assign cnt_lo     = cnt[ADDR_BITS-1:0];
  assign abort_ok   = i_abort && (state inside {CLEAR, FEED, FLUSH});

  // NOTE: state and every output register use non-blocking assignments so all of
  // them update together from the same pre-edge values; the async reset clears the
  // outputs too, so tvalid and busy drop the moment reset asserts.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state         <= IDLE;
      n_m1          <= '0;
      cnt           <= '0;
      array_reset_q <= 1'b0;
      array_valid_q <= 1'b0;
      feed_addr_q   <= '0;
      feed_zero_q   <= 1'b0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      array_reset_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;

      if (abort_ok) begin
        state         <= IDLE;
        cnt           <= '0;
        array_valid_q <= 1'b0;
        feed_addr_q   <= '0;
        feed_zero_q   <= 1'b0;
        busy_q        <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (i_start) begin
              if (size_ok) begin
                state         <= CLEAR;
                n_m1          <= n_req_m1;
                cnt           <= '0;
                array_reset_q <= 1'b1;
                busy_q        <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end
          end

          CLEAR: begin
            state         <= FEED;
            cnt           <= '0;
            array_valid_q <= 1'b1;
            feed_addr_q   <= '0;
            feed_zero_q   <= 1'b0;
          end

          FEED: begin
            if (cnt_lo == n_m1) begin
              state       <= FLUSH;
              cnt         <= '0;
              feed_addr_q <= '0;
              feed_zero_q <= 1'b1;
            end else begin
              cnt         <= cnt + (ADDR_BITS+1)'(1);
              feed_addr_q <= cnt_lo + ADDR_BITS'(1);
            end
          end

          FLUSH: begin
            if (cnt == flush_last) begin
              state         <= STREAM;
              cnt           <= '0;
              array_valid_q <= 1'b0;
              feed_zero_q   <= 1'b0;
              tvalid_q      <= 1'b1;
              tlast_q       <= (n_m1 == '0);
            end else begin
              cnt <= cnt + (ADDR_BITS+1)'(1);
            end
          end

          STREAM: begin
            // Beat counter only moves on a handshake; tvalid stays up through stalls.
            if (m00_axis.tready) begin
              if (cnt_lo == n_m1) begin
                state    <= IDLE;
                cnt      <= '0;
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
              end else begin
                cnt     <= cnt + (ADDR_BITS+1)'(1);
                tlast_q <= ((cnt_lo + ADDR_BITS'(1)) == n_m1);
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  assign o_array_reset   = array_reset_q;
  assign o_array_valid   = array_valid_q;
  assign o_feed_addr     = feed_addr_q;
  assign o_feed_zero     = feed_zero_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_err           = err_q;
  assign m00_axis.tvalid = tvalid_q;
  assign m00_axis.tlast  = tlast_q;
  assign o_diag_shift    = tvalid_q & m00_axis.tready;

endmodule

// File: tb/tb_mmu_sequencer.sv
// Directed bench for mmu_sequencer (SIZE=4): a per-cycle vector table for a full run,
// plus hand sequences for stalls, illegal size, abort, ignored requests and async reset.
module tb_mmu_sequencer;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_start = 1'b0;
  logic       i_abort = 1'b0;
  logic [2:0] rf_matrix_size = 3'd1;
  logic       o_array_reset, o_array_valid, o_feed_zero, o_diag_shift;
  logic [1:0] o_feed_addr;
  logic       o_busy, o_done, o_err;

  mmu_sequencer_if axis ();

  mmu_sequencer dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_start        (i_start),
    .i_abort        (i_abort),
    .rf_matrix_size (rf_matrix_size),
    .o_array_reset  (o_array_reset),
    .o_array_valid  (o_array_valid),
    .o_feed_addr    (o_feed_addr),
    .o_feed_zero    (o_feed_zero),
    .o_diag_shift   (o_diag_shift),
    .m00_axis       (axis.master),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_err          (o_err)
  );

  always #5 i_clock = ~i_clock;

  // exp bit order: reset valid addr[1:0] zero shift tvalid tlast busy done err
  typedef struct packed {
    logic        start;
    logic        abort;
    logic        tready;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[18];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  function automatic logic [10:0] out_vec();
    return {o_array_reset, o_array_valid, o_feed_addr, o_feed_zero, o_diag_shift,
            axis.tvalid, axis.tlast, o_busy, o_done, o_err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic step(input logic s, input logic a, input logic r);
    @(negedge i_clock);
    i_start     = s;
    i_abort     = a;
    axis.tready = r;
    #1;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 18; i++) begin
      step(vecs[i].start, vecs[i].abort, vecs[i].tready);
      check($sformatf("%s_cyc%0d", tag, i), 32'(out_vec()), 32'(vecs[i].exp));
    end
  endtask

  initial begin
    int busy_n, done_n, reset_n, tvalid_n, err_n, beats, budget;

    // Cycle k after the start cycle; N=4, tready held high.
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 11'b0_0_00_0_0_0_0_0_0_0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 11'b1_0_00_0_0_0_0_1_0_0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 11'b0_1_00_0_0_0_0_1_0_0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 11'b0_1_01_0_0_0_0_1_0_0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 11'b0_1_10_0_0_0_0_1_0_0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 11'b0_1_11_0_0_0_0_1_0_0};
    for (int i = 6; i < 12; i++)
      vecs[i] = '{1'b0, 1'b0, 1'b1, 11'b0_1_00_1_0_0_0_1_0_0};
    for (int i = 12; i < 15; i++)
      vecs[i] = '{1'b0, 1'b0, 1'b1, 11'b0_0_00_0_1_1_0_1_0_0};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 11'b0_0_00_0_1_1_1_1_0_0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 11'b0_0_00_0_0_0_0_0_1_0};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 11'b0_0_00_0_0_0_0_0_0_0};

    axis.tready = 1'b0;
    #12;
    check("reset_state", 32'(out_vec()), 32'h0);
    @(negedge i_clock);
    i_reset = 1'b1;

    // Full run, cycle by cycle.
    rf_matrix_size = 3'd1;
    run_table("run1");

    // Back-pressure: tready alternates during STREAM.
    step(1'b1, 1'b0, 1'b0);
    budget = 0;
    while (!axis.tvalid && budget < 40) begin
      step(1'b0, 1'b0, 1'b0);
      budget++;
    end
    check("stall_reach_stream", 32'(axis.tvalid), 32'd1);
    beats = 0; done_n = 0;
    for (int j = 0; j < 12; j++) begin
      if (j > 0) @(negedge i_clock);
      axis.tready = (j % 2 == 0);
      #1;
      if (beats < 4) check($sformatf("stall_tvalid_%0d", j), 32'(axis.tvalid), 32'd1);
      if (axis.tvalid)
        check($sformatf("stall_tlast_%0d", j), 32'(axis.tlast), 32'(beats == 3));
      if (o_diag_shift) beats++;
      if (o_done) done_n++;
    end
    check("stall_shift_count", 32'(beats), 32'd4);
    check("stall_done_count", 32'(done_n), 32'd1);

    // Illegal size: N=8 on a 4x4 array.
    rf_matrix_size = 3'd2;
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("illegal_cycle1", 32'(out_vec()), 32'h001);
    step(1'b0, 1'b0, 1'b1);
    check("illegal_cycle2", 32'(out_vec()), 32'h000);
    rf_matrix_size = 3'd1;

    // Abort while feeding address 2, then a clean run.
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("abort_at_addr2", 32'(o_feed_addr), 32'd2);
    step(1'b0, 1'b0, 1'b1);
    check("abort_outputs", 32'(out_vec()), 32'h000);
    step(1'b1, 1'b0, 1'b1);
    busy_n = 0; done_n = 0;
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 1'b0, 1'b1);
      busy_n += int'(o_busy);
      done_n += int'(o_done);
    end
    check("abort_rerun_busy", 32'(busy_n), 32'd15);
    check("abort_rerun_done", 32'(done_n), 32'd1);

    // Start held every cycle, abort during STREAM, size changed mid-run.
    busy_n = 0; done_n = 0; reset_n = 0; tvalid_n = 0; err_n = 0;
    for (int k = 0; k < 30; k++) begin
      if (k == 2) rf_matrix_size = 3'd2;
      step(k < 16, (k >= 12 && k < 16), 1'b1);
      busy_n   += int'(o_busy);
      done_n   += int'(o_done);
      reset_n  += int'(o_array_reset);
      tvalid_n += int'(axis.tvalid);
      err_n    += int'(o_err);
    end
    check("ignore_busy", 32'(busy_n), 32'd15);
    check("ignore_done", 32'(done_n), 32'd1);
    check("ignore_resets", 32'(reset_n), 32'd1);
    check("ignore_beats", 32'(tvalid_n), 32'd4);
    check("ignore_err", 32'(err_n), 32'd0);
    rf_matrix_size = 3'd1;

    // Async reset during beat 2, then a fresh full run.
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 1'b1);
    check("arst_in_beat2", 32'({axis.tvalid, axis.tlast, o_busy}), 32'b101);
    #2;
    i_reset = 1'b0;
    #1;
    check("arst_immediate", 32'(out_vec()), 32'h000);
    @(negedge i_clock);
    i_reset = 1'b1;
    run_table("run2");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
